// File: rtl/snn_pkg.sv
// Shared constants and types for the SNN host-side image loader.
package snn_pkg;

  localparam int unsigned NUM_PIXELS = 784;
  localparam int unsigned NUM_BYTES  = 98;
  localparam int unsigned RAM_DEPTH  = 128;
  localparam int unsigned RAM_AW     = 7;

  localparam logic [7:0] ASCII_BASE = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  typedef enum logic [2:0] {
    StLoad,
    StStart,
    StRun,
    StTxSend,
    StTxGap,
    StTxWait
  } loader_state_e;

  // Digits above 9 are deliberately passed through unmodified.
  function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
    return ASCII_BASE + {4'b0000, d};
  endfunction

endpackage

// File: rtl/img_byte_ram.sv
// 128x8 image byte buffer: one write port, one synchronous read port, no reset.
module img_byte_ram
  import snn_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [RAM_AW-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [RAM_AW-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [RAM_DEPTH];

  // Write and registered read share the clock edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/snn_image_loader.sv
// Host-side front end for the SNN classifier core: loads a 98-byte binary image
// from the UART, serves it to the core, then returns the digit as ASCII.
// Optional macro SNN_IMAGE_LOADER_CRLF_EN appends CR and LF after the digit byte.
module snn_image_loader
  import snn_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_rdy,
  input  logic [9:0] addr_input_unit,
  output logic       q_input,
  output logic       start,
  input  logic       done,
  input  logic [3:0] digit,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       busy
);

  localparam logic [RAM_AW-1:0] LastByte = RAM_AW'(NUM_BYTES - 1);

  loader_state_e     state_q, state_d;
  logic [RAM_AW-1:0] byte_cnt_q, byte_cnt_d;
  logic              start_q, start_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              busy_q, busy_d;
  logic              ram_we;
  logic [7:0]        ram_rdata;
  logic [2:0]        bit_sel_q;
  logic              rd_valid_q;
  logic              tx_last;
  logic [7:0]        next_tx_byte;

  img_byte_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (byte_cnt_q),
    .wdata (rx_data),
    .raddr (addr_input_unit[9:3]),
    .rdata (ram_rdata)
  );

`ifdef SNN_IMAGE_LOADER_CRLF_EN
  // Index of the byte in flight: 0 = digit, 1 = CR, 2 = LF.
  logic [1:0] tx_idx_q, tx_idx_d;

  assign tx_last      = (tx_idx_q == 2'd2);
  assign next_tx_byte = (tx_idx_q == 2'd0) ? ASCII_CR : ASCII_LF;

  // Advance the byte index on each completed transmit, restart it on a new result.
  always_comb begin
    tx_idx_d = tx_idx_q;
    if (state_q == StRun && done) begin
      tx_idx_d = 2'd0;
    end else if (state_q == StTxWait && !tx_busy && !tx_last) begin
      tx_idx_d = tx_idx_q + 2'd1;
    end
  end

  // Byte index register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_idx_q <= 2'd0;
    end else begin
      tx_idx_q <= tx_idx_d;
    end
  end
`else
  assign tx_last      = 1'b1;
  assign next_tx_byte = tx_data_q;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StLoad;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad:   if (rx_rdy && byte_cnt_q == LastByte) state_d = StStart;
      StStart:  state_d = StRun;
      StRun:    if (done) state_d = StTxSend;
      StTxSend: if (!tx_busy) state_d = StTxGap;
      // tx_busy only rises the cycle after tx_start, so skip one cycle before watching it.
      StTxGap:  state_d = StTxWait;
      StTxWait: if (!tx_busy) state_d = tx_last ? StLoad : StTxSend;
      default:  state_d = StLoad;
    endcase
  end

  // Output and datapath next values; all outputs are registered below.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    start_d    = 1'b0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    ram_we     = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (rx_rdy) begin
          ram_we     = 1'b1;
          busy_d     = 1'b1;
          byte_cnt_d = (byte_cnt_q == LastByte) ? '0 : byte_cnt_q + 1'b1;
        end
      end
      StStart:  start_d = 1'b1;
      StRun:    if (done) tx_data_d = digit_to_ascii(digit);
      StTxSend: if (!tx_busy) tx_start_d = 1'b1;
      StTxWait: begin
        if (!tx_busy) begin
          if (tx_last) begin
            busy_d = 1'b0;
          end else begin
            tx_data_d = next_tx_byte;
          end
        end
      end
      default: ;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q <= '0;
      start_q    <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      start_q    <= start_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
    end
  end

  // Read-side pipeline: bit select and range flag travel with the RAM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_sel_q  <= 3'd0;
      rd_valid_q <= 1'b0;
    end else begin
      bit_sel_q  <= addr_input_unit[2:0];
      rd_valid_q <= (addr_input_unit < 10'(NUM_PIXELS));
    end
  end

  // Out-of-range reads hit unwritten RAM, so the range flag must gate the data.
  assign q_input  = rd_valid_q & ram_rdata[bit_sel_q];
  assign start    = start_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;

endmodule
